// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the pipeline hazard / forwarding controller.
//   FWD_RF / FWD_M / FWD_W : E-stage operand select encodings
//   pipe_ent_t             : one in-flight register writer (shadow pipe entry)
//   match()                : does a writer entry produce the given source reg?
// Register addresses are carried at MAX_REG_AW bits inside the package types.
// The top zero-extends its REG_AW-wide addresses, so REG_AW must not exceed
// MAX_REG_AW.
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    localparam int MAX_REG_AW = 8;

    typedef logic [MAX_REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        logic      regwrite;
        logic      load;
    } pipe_ent_t;

    localparam pipe_ent_t ENT_EMPTY = '0;

    // Register 0 is hard-wired zero, so a write to it never creates a hazard.
    function automatic logic match(input pipe_ent_t ent, input reg_addr_t src);
        return ent.valid && ent.regwrite && (ent.rd != '0) && (ent.rd == src);
    endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   reset : synchronous, active-high; clears the count
//   inc   : add one this cycle (ignored once saturated)
//   q     : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Hazard and forwarding controller for the 5-stage F/D/E/M/W datapath. Keeps
// a shadow copy of the register writers in E, M and W and from it derives the
// pipeline-register enables, bubble/flush requests and E-stage forward selects.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   dec_valid           : D-stage instruction valid
//   dec_rs1/rs2/rd      : D-stage source / destination registers
//   dec_regwrite        : D instruction writes rd
//   dec_load            : D instruction is a load
//   redirect            : taken branch/jump resolved in M
//   dhit                : data-memory hit; low freezes the whole pipe
//   pc_en_f             : enable of PC and F/D register
//   en_de               : enable of D/E register
//   bubble_e            : load D/E with a NOP
//   flush_m             : load E/M with a NOP
//   fwd_a / fwd_b       : E operand select (00 regfile, 01 ALUOutM, 10 ResultW)
//   stall_cnt           : saturating count of hazard-stall cycles
//   flush_cnt           : saturating count of redirects taken
//
// Handshake: the pipe has no valid/ready pairs; a stage advances on a clock
// edge only when its enable is high, and a bubble/flush replaces the incoming
// instruction with a NOP in the same edge.
// -----------------------------------------------------------------------------
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter bit FWD_EN    = 1'b1,
    parameter bit RF_BYPASS = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_regwrite,
    input  logic              dec_load,
    input  logic              redirect,
    input  logic              dhit,
    output logic              pc_en_f,
    output logic              en_de,
    output logic              bubble_e,
    output logic              flush_m,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // Per-cycle pipe action, in priority order.
    localparam logic [1:0] MODE_NORMAL   = 2'd0;
    localparam logic [1:0] MODE_STALL    = 2'd1;
    localparam logic [1:0] MODE_REDIRECT = 2'd2;
    localparam logic [1:0] MODE_FREEZE   = 2'd3;

    pipe_ent_t e_q, e_d;
    pipe_ent_t m_q, m_d;
    pipe_ent_t w_q, w_d;
    reg_addr_t e_rs1_q, e_rs1_d;
    reg_addr_t e_rs2_q, e_rs2_d;

    reg_addr_t d_rs1;
    reg_addr_t d_rs2;
    reg_addr_t d_rd;
    logic      hazard;
    logic [1:0] mode;

    assign d_rs1 = reg_addr_t'(dec_rs1);
    assign d_rs2 = reg_addr_t'(dec_rs2);
    assign d_rd  = reg_addr_t'(dec_rd);

    // M wins over W because it holds the younger value of the register.
    // A load in M has no data yet, so it is never a forward source.
    function automatic logic [1:0] fwd_sel(input pipe_ent_t m, input pipe_ent_t w,
                                           input reg_addr_t src);
        logic [1:0] sel;
        sel = FWD_RF;
        if (FWD_EN) begin
            if (match(m, src) && !m.load) begin
                sel = FWD_M;
            end else if (match(w, src)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    always_comb begin
        hazard = 1'b0;
        if (dec_valid) begin
            if (FWD_EN) begin
                // Only load-use needs a stall; everything else is forwarded.
                hazard = e_q.load && (match(e_q, d_rs1) || match(e_q, d_rs2));
            end else begin
                hazard = match(e_q, d_rs1) || match(e_q, d_rs2) ||
                         match(m_q, d_rs1) || match(m_q, d_rs2) ||
                         (!RF_BYPASS && (match(w_q, d_rs1) || match(w_q, d_rs2)));
            end
        end

        if (!dhit) begin
            mode = MODE_FREEZE;
        end else if (redirect) begin
            mode = MODE_REDIRECT;
        end else if (hazard) begin
            mode = MODE_STALL;
        end else begin
            mode = MODE_NORMAL;
        end
    end

    always_comb begin
        pc_en_f  = 1'b1;
        en_de    = 1'b1;
        bubble_e = 1'b0;
        flush_m  = 1'b0;
        e_d      = e_q;
        m_d      = m_q;
        w_d      = w_q;
        e_rs1_d  = e_rs1_q;
        e_rs2_d  = e_rs2_q;

        case (mode)
            MODE_FREEZE: begin
                pc_en_f = 1'b0;
                en_de   = 1'b0;
            end
            MODE_REDIRECT: begin
                // Wrong-path instructions in E and M are squashed; the one in
                // M's slot already committed nothing, the older one moves on.
                bubble_e = 1'b1;
                flush_m  = 1'b1;
                e_d      = ENT_EMPTY;
                e_rs1_d  = '0;
                e_rs2_d  = '0;
                m_d      = ENT_EMPTY;
                w_d      = m_q;
            end
            MODE_STALL: begin
                pc_en_f  = 1'b0;
                en_de    = 1'b0;
                bubble_e = 1'b1;
                e_d      = ENT_EMPTY;
                e_rs1_d  = '0;
                e_rs2_d  = '0;
                m_d      = e_q;
                w_d      = m_q;
            end
            default: begin
                e_d.valid    = dec_valid;
                e_d.rd       = d_rd;
                e_d.regwrite = dec_regwrite;
                e_d.load     = dec_load;
                e_rs1_d      = d_rs1;
                e_rs2_d      = d_rs2;
                m_d          = e_q;
                w_d          = m_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q     <= ENT_EMPTY;
            m_q     <= ENT_EMPTY;
            w_q     <= ENT_EMPTY;
            e_rs1_q <= '0;
            e_rs2_q <= '0;
        end else begin
            e_q     <= e_d;
            m_q     <= m_d;
            w_q     <= w_d;
            e_rs1_q <= e_rs1_d;
            e_rs2_q <= e_rs2_d;
        end
    end

    assign fwd_a = fwd_sel(m_q, w_q, e_rs1_q);
    assign fwd_b = fwd_sel(m_q, w_q, e_rs2_q);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mode == MODE_STALL),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (mode == MODE_REDIRECT),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Four instances with different parameter sets, each driven independently:
//   0 : FWD_EN=1, RF_BYPASS=1, CNT_W=32
//   1 : FWD_EN=0, RF_BYPASS=1, CNT_W=32
//   2 : FWD_EN=0, RF_BYPASS=0, CNT_W=32
//   3 : FWD_EN=1, RF_BYPASS=1, CNT_W=4  (saturation)
// Output vector per instance: {pc_en_f, en_de, bubble_e, flush_m, fwd_a, fwd_b}
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    localparam logic [7:0] NORM   = 8'b1100_0000;
    localparam logic [7:0] STALL  = 8'b0010_0000;
    localparam logic [7:0] FREEZE = 8'b0000_0000;
    localparam logic [7:0] REDIR  = 8'b1111_0000;
    localparam logic [7:0] NORM_W = 8'b1100_1010;
    localparam logic [7:0] NORM_M = 8'b1100_0100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [3:0]       dec_valid;
    logic [3:0][4:0]  dec_rs1;
    logic [3:0][4:0]  dec_rs2;
    logic [3:0][4:0]  dec_rd;
    logic [3:0]       dec_regwrite;
    logic [3:0]       dec_load;
    logic [3:0]       redirect;
    logic [3:0]       dhit;
    logic [3:0]       pc_en_f;
    logic [3:0]       en_de;
    logic [3:0]       bubble_e;
    logic [3:0]       flush_m;
    logic [3:0][1:0]  fwd_a;
    logic [3:0][1:0]  fwd_b;
    logic [3:0][31:0] stall_c;
    logic [3:0][31:0] flush_c;
    logic [3:0]       sc3;
    logic [3:0]       fc3;

    assign stall_c[3] = {28'd0, sc3};
    assign flush_c[3] = {28'd0, fc3};

    hazard_unit #(.REG_AW(5), .FWD_EN(1'b1), .RF_BYPASS(1'b1), .CNT_W(32)) u_dut0 (
        .clk(clk), .reset(reset), .dec_valid(dec_valid[0]), .dec_rs1(dec_rs1[0]),
        .dec_rs2(dec_rs2[0]), .dec_rd(dec_rd[0]), .dec_regwrite(dec_regwrite[0]),
        .dec_load(dec_load[0]), .redirect(redirect[0]), .dhit(dhit[0]),
        .pc_en_f(pc_en_f[0]), .en_de(en_de[0]), .bubble_e(bubble_e[0]),
        .flush_m(flush_m[0]), .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]),
        .stall_cnt(stall_c[0]), .flush_cnt(flush_c[0]));

    hazard_unit #(.REG_AW(5), .FWD_EN(1'b0), .RF_BYPASS(1'b1), .CNT_W(32)) u_dut1 (
        .clk(clk), .reset(reset), .dec_valid(dec_valid[1]), .dec_rs1(dec_rs1[1]),
        .dec_rs2(dec_rs2[1]), .dec_rd(dec_rd[1]), .dec_regwrite(dec_regwrite[1]),
        .dec_load(dec_load[1]), .redirect(redirect[1]), .dhit(dhit[1]),
        .pc_en_f(pc_en_f[1]), .en_de(en_de[1]), .bubble_e(bubble_e[1]),
        .flush_m(flush_m[1]), .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]),
        .stall_cnt(stall_c[1]), .flush_cnt(flush_c[1]));

    hazard_unit #(.REG_AW(5), .FWD_EN(1'b0), .RF_BYPASS(1'b0), .CNT_W(32)) u_dut2 (
        .clk(clk), .reset(reset), .dec_valid(dec_valid[2]), .dec_rs1(dec_rs1[2]),
        .dec_rs2(dec_rs2[2]), .dec_rd(dec_rd[2]), .dec_regwrite(dec_regwrite[2]),
        .dec_load(dec_load[2]), .redirect(redirect[2]), .dhit(dhit[2]),
        .pc_en_f(pc_en_f[2]), .en_de(en_de[2]), .bubble_e(bubble_e[2]),
        .flush_m(flush_m[2]), .fwd_a(fwd_a[2]), .fwd_b(fwd_b[2]),
        .stall_cnt(stall_c[2]), .flush_cnt(flush_c[2]));

    hazard_unit #(.REG_AW(5), .FWD_EN(1'b1), .RF_BYPASS(1'b1), .CNT_W(4)) u_dut3 (
        .clk(clk), .reset(reset), .dec_valid(dec_valid[3]), .dec_rs1(dec_rs1[3]),
        .dec_rs2(dec_rs2[3]), .dec_rd(dec_rd[3]), .dec_regwrite(dec_regwrite[3]),
        .dec_load(dec_load[3]), .redirect(redirect[3]), .dhit(dhit[3]),
        .pc_en_f(pc_en_f[3]), .en_de(en_de[3]), .bubble_e(bubble_e[3]),
        .flush_m(flush_m[3]), .fwd_a(fwd_a[3]), .fwd_b(fwd_b[3]),
        .stall_cnt(sc3), .flush_cnt(fc3));

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [7:0] obs(input int id);
        return {pc_en_f[id], en_de[id], bubble_e[id], flush_m[id], fwd_a[id], fwd_b[id]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_d(input int id, input logic v, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic ld);
        dec_valid[id]    = v;
        dec_rs1[id]      = rs1;
        dec_rs2[id]      = rs2;
        dec_rd[id]       = rd;
        dec_regwrite[id] = rw;
        dec_load[id]     = ld;
    endtask

    task automatic idle(input int id);
        set_d(id, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic lw7(input int id);
        set_d(id, 1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
    endtask

    task automatic add8(input int id);
        set_d(id, 1'b1, 5'd7, 5'd7, 5'd8, 1'b1, 1'b0);
    endtask

    // One clock cycle on instance id: record the expected outputs, sample them
    // mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input int id, input logic [7:0] exp, input string tag);
        logic [7:0] got;
        logic [7:0] e;
        exp_q.push_back(exp);
        @(negedge clk);
        got = obs(id);
        e = exp_q.pop_front();
        n_tests++;
        assert (got === e) else begin
            n_fail++;
            $error("FAIL %s (dut%0d): observed %b expected %b", tag, id, got, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input int id, input string tag,
                           input logic [31:0] exp_stall, input logic [31:0] exp_flush);
        n_tests++;
        assert (stall_c[id] === exp_stall) else begin
            n_fail++;
            $error("FAIL %s stall_cnt (dut%0d): observed %0d expected %0d",
                   tag, id, stall_c[id], exp_stall);
        end
        n_tests++;
        assert (flush_c[id] === exp_flush) else begin
            n_fail++;
            $error("FAIL %s flush_cnt (dut%0d): observed %0d expected %0d",
                   tag, id, flush_c[id], exp_flush);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 4; i++) begin
            idle(i);
            redirect[i] = 1'b0;
            dhit[i]     = 1'b1;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state, all instances, same cycle.
        for (int i = 0; i < 4; i++) exp_q.push_back(NORM);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            n_tests++;
            assert (obs(i) === e) else begin
                n_fail++;
                $error("FAIL reset_out (dut%0d): observed %b expected %b", i, obs(i), e);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) chk_cnt(i, "reset", 32'd0, 32'd0);

        // ---- dut0: back-to-back ALU RAW, forwarded from M ----
        set_d(0, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        cyc(0, NORM, "raw_add5");
        set_d(0, 1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0);
        cyc(0, NORM, "raw_add6_no_stall");
        idle(0);
        cyc(0, NORM_M, "raw_fwd_a_M");
        cyc(0, NORM, "raw_drain");
        chk_cnt(0, "raw", 32'd0, 32'd0);
        cyc(0, NORM, "drain");
        cyc(0, NORM, "drain");

        // ---- dut0: load-use, one bubble then W forward ----
        lw7(0);
        cyc(0, NORM, "lu_lw");
        add8(0);
        cyc(0, STALL, "lu_stall");
        cyc(0, NORM, "lu_reissue");
        idle(0);
        cyc(0, NORM_W, "lu_fwd_W");
        chk_cnt(0, "loaduse", 32'd1, 32'd0);
        repeat (3) cyc(0, NORM, "drain");

        // ---- dut0: writer to x0 never hazards ----
        set_d(0, 1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1);
        cyc(0, NORM, "x0_lw");
        set_d(0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        cyc(0, NORM, "x0_reader_no_stall");
        idle(0);
        cyc(0, NORM, "x0_no_fwd");
        chk_cnt(0, "x0", 32'd1, 32'd0);
        repeat (2) cyc(0, NORM, "drain");

        // ---- dut0: redirect beats a pending load-use ----
        lw7(0);
        cyc(0, NORM, "rd_lw");
        add8(0);
        redirect[0] = 1'b1;
        cyc(0, REDIR, "rd_redirect");
        redirect[0] = 1'b0;
        cyc(0, NORM, "rd_E_invalid");
        idle(0);
        cyc(0, NORM, "rd_M_invalid_no_fwd");
        chk_cnt(0, "redirect", 32'd1, 32'd1);
        repeat (2) cyc(0, NORM, "drain");

        // ---- dut0: dhit low during load-use, redirect ignored ----
        lw7(0);
        cyc(0, NORM, "dh_lw");
        add8(0);
        dhit[0] = 1'b0;
        cyc(0, FREEZE, "dh_freeze1");
        redirect[0] = 1'b1;
        cyc(0, FREEZE, "dh_freeze2_redirect");
        redirect[0] = 1'b0;
        cyc(0, FREEZE, "dh_freeze3");
        chk_cnt(0, "dh_frozen", 32'd1, 32'd1);
        dhit[0] = 1'b1;
        cyc(0, STALL, "dh_stall");
        cyc(0, NORM, "dh_reissue");
        idle(0);
        cyc(0, NORM_W, "dh_fwd_W");
        chk_cnt(0, "dh_after", 32'd2, 32'd1);

        // ---- dut1: no forwarding, regfile bypass ----
        set_d(1, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        cyc(1, NORM, "nf_add5");
        set_d(1, 1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0);
        cyc(1, STALL, "nf_stall_E");
        cyc(1, STALL, "nf_stall_M");
        cyc(1, NORM, "nf_go");
        idle(1);
        cyc(1, NORM, "nf_no_fwd");
        chk_cnt(1, "nf_add", 32'd2, 32'd0);
        lw7(1);
        cyc(1, NORM, "nf_lw");
        add8(1);
        cyc(1, STALL, "nf_lu_stall1");
        cyc(1, STALL, "nf_lu_stall2");
        cyc(1, NORM, "nf_lu_go");
        idle(1);
        cyc(1, NORM, "nf_lu_no_fwd");
        chk_cnt(1, "nf_lu", 32'd4, 32'd0);

        // ---- dut2: no forwarding, no regfile bypass ----
        set_d(2, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        cyc(2, NORM, "nb_add5");
        set_d(2, 1'b1, 5'd3, 5'd5, 5'd6, 1'b1, 1'b0);
        cyc(2, STALL, "nb_stall_E");
        cyc(2, STALL, "nb_stall_M");
        cyc(2, STALL, "nb_stall_W");
        cyc(2, NORM, "nb_go");
        idle(2);
        cyc(2, NORM, "nb_no_fwd");
        chk_cnt(2, "nb_add", 32'd3, 32'd0);

        // ---- dut3: 4-bit stall counter saturates ----
        for (int i = 0; i < 17; i++) begin
            lw7(3);
            cyc(3, (i == 0) ? NORM : NORM_W, "sat_lw");
            add8(3);
            cyc(3, STALL, "sat_stall");
            cyc(3, NORM, "sat_reissue");
            if (i == 13) chk_cnt(3, "sat_14", 32'd14, 32'd0);
        end
        chk_cnt(3, "sat_hold", 32'd15, 32'd0);

        // ---- reset in the middle of a stall ----
        lw7(0);
        cyc(0, NORM, "rst_lw");
        add8(0);
        reset = 1'b1;
        cyc(0, STALL, "rst_stall_cycle");
        reset = 1'b0;
        chk_cnt(0, "rst", 32'd0, 32'd0);
        chk_cnt(3, "rst", 32'd0, 32'd0);
        cyc(0, NORM, "rst_E_cleared");
        idle(0);
        cyc(0, NORM, "rst_no_fwd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipelined datapath (F/D/E/M/W); successor to the current datapath, which has no RAW, load-use or memory-stall handling.
- Keeps its own shadow pipeline of in-flight register writers (E, M, W) and drives pipeline-register enables, bubble/flush requests and E-stage forwarding selects.
- Adds a no-forward mode and saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register-address width; address 0 is hard-wired zero and never hazards.
- FWD_EN, 1, 1 = forwarding from M/W into E; 0 = stall on any RAW hazard.
- RF_BYPASS, 1, 1 = regfile returns same-cycle write data on read; 0 = W-stage writer is also a D-stage hazard.
- CNT_W, 32, performance-counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- dec_valid  in  1  D-stage instruction valid
- dec_rs1  in  REG_AW  D source 1
- dec_rs2  in  REG_AW  D source 2
- dec_rd  in  REG_AW  D destination
- dec_regwrite  in  1  D instruction writes rd
- dec_load  in  1  D instruction is a load
- redirect  in  1  taken branch or jump resolved in M
- dhit  in  1  data-memory hit; 0 freezes the pipe
- pc_en_f  out  1  enable of PC and F/D register
- en_de  out  1  enable of D/E register
- bubble_e  out  1  load D/E with a NOP this cycle
- flush_m  out  1  load E/M with a NOP this cycle
- fwd_a  out  2  E source-A select: 00 regfile, 01 ALUOutM, 10 ResultW
- fwd_b  out  2  E source-B select, same encoding
- stall_cnt  out  CNT_W  cycles with a hazard stall
- flush_cnt  out  CNT_W  redirects taken

Behaviour:
- Shadow entries for E, M and W; each holds valid, rd, regwrite and load. The E entry also holds rs1 and rs2.
- Reset: all entries invalid, counters 0. Outputs on the cycle after reset: pc_en_f = 1, en_de = 1, bubble_e = 0, flush_m = 0, fwd_a = fwd_b = 00.
- A writer "matches" a source when: entry valid, regwrite = 1, rd != 0, and rd == source.
- Priority per cycle: dhit = 0 > redirect > hazard stall > normal.
- dhit = 0:
  - pc_en_f = en_de = 0; bubble_e = flush_m = 0.
  - Shadow entries and counters hold.
  - A redirect or hazard arriving in the same cycle is ignored until dhit returns.
- redirect = 1 (dhit = 1):
  - bubble_e = 1 and flush_m = 1; pc_en_f = en_de = 1.
  - Next edge: E and M entries become invalid; W takes the old M entry.
  - flush_cnt increments.
  - A coincident hazard is discarded and does not count as a stall.
- Hazard stall:
  - FWD_EN = 1: a hazard exists when a D source matches the E entry and E.load = 1 (load-use).
  - FWD_EN = 0: a hazard exists when a D source matches E or M, or matches W when RF_BYPASS = 0.
  - Only evaluated when dec_valid = 1.
  - Outputs: pc_en_f = en_de = 0, bubble_e = 1.
  - Next edge: E becomes invalid, M <= E, W <= M. stall_cnt increments.
  - The stall re-evaluates every cycle, so multi-cycle stalls in no-forward mode fall out naturally.
- Normal:
  - All enables 1.
  - Next edge: E <= D fields, valid = dec_valid; M <= E; W <= M.
- Forwarding (FWD_EN = 1, combinational from registered entries), evaluated per E source:
  - Source matches M and M.load = 0 → 01.
  - Otherwise source matches W → 10.
  - Otherwise 00.
  - M has precedence over W.
  - FWD_EN = 0 → always 00.
- Counters saturate at all-ones (no wrap).
- Reset mid-stall or mid-redirect: the state above applies on the next edge regardless of other inputs.
- Load-use latency: exactly 1 bubble when FWD_EN = 1. The load's data then reaches E through the W path (10).

Decomposition:
- Package hazard_pkg:
  - FWD_RF = 2'b00, FWD_M = 2'b01, FWD_W = 2'b10.
  - Struct pipe_ent_t {valid, rd, regwrite, load}.
  - Function match(ent, src).
- One sub-module, sat_counter (parameter W; ports inc, clk, reset, q), instantiated twice.

Test Plan:
- add x5 ← x1,x2 then add x6 ← x5,x3 back-to-back, FWD_EN = 1 → fwd_a = 01 on the second instruction's E cycle; no stall; stall_cnt = 0.
- lw x7, then add x8 ← x7,x7 next, FWD_EN = 1:
  - 1 cycle with pc_en_f = 0 and bubble_e = 1.
  - Then fwd_a = fwd_b = 10.
  - stall_cnt = 1.
- Same add sequence with FWD_EN = 0, RF_BYPASS = 1 → 2 stall cycles; fwd selects stay 00; stall_cnt = 2. With RF_BYPASS = 0 → 3 stall cycles.
- Writer with rd = x0 followed by a reader of x0 → no stall; fwd = 00.
- redirect = 1 in the same cycle as a pending load-use → bubble_e = flush_m = 1; E/M invalid next cycle; flush_cnt = 1; stall_cnt unchanged.
- dhit = 0 for 3 cycles during a load-use hazard → enables 0, no bubble, counters frozen. After dhit = 1: the normal single load-use stall, stall_cnt = 1.
- Force stall_cnt to all-ones with CNT_W = 4 (16+ stalls) → value stays 4'hF.
